dsp_p_unpacker: RTL
===================

# dsp_p_unpacker

Drain-side companion to the DSP48A1 result pipeline. It accepts 48-bit P results from the final P register stage on a valid/ready handshake, holds up to two of them in a small buffer, and serializes each result onto a narrower OUT_W-bit stream, least-significant slice first. It sits between the DSP slice's P output and downstream logic that cannot take a full 48-bit word per cycle.

## Interface

- OUT_W, 16, output beat width; legal values are 8, 12, 16, 24 and 48. BEATS = 48/OUT_W.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; synchronous and active-low. It has priority over CE.
- CE  in  1  clock enable. When low, all state is frozen.
- P_IN  in  48  result word from the DSP P register.
- P_VALID  in  1  P_IN is valid.
- P_READY  out  1  block can accept a word; P_READY = CE && (count < 2).
- D_OUT  out  OUT_W  current beat, equal to head[beat*OUT_W +: OUT_W].
- D_VALID  out  1  D_OUT is valid; D_VALID = (count != 0).
- D_READY  in  1  downstream accepts the beat.
- D_LAST  out  1  current beat is beat BEATS-1 of its word.
- BUSY  out  1  high when count != 0.

## Operation

- Buffer: 2-entry FIFO (head/tail) with a 2-bit count (0..2) and a beat counter of width clog2(BEATS), minimum 1 bit.
- Push: occurs when P_VALID && P_READY at the edge. P_IN is written at the tail and count increments.
- Beat transfer: occurs when CE && D_VALID && D_READY at the edge.
  - Non-last beat: beat increments.
  - Last beat (beat == BEATS-1): head pops, beat returns to 0, and count decrements.
- Simultaneous push and pop: count stays the same and both pointers advance.
- Full (count == 2): P_READY is low, so no push can occur, even when a pop happens in the same cycle. There is no pass-through.
- Empty: D_VALID is low. D_OUT is don't-care; the implementation drives the head slice.
- CE low:
  - No push, no beat transfer, no state change.
  - P_READY is low.
  - D_VALID, D_OUT and D_LAST keep their values, because they depend only on frozen state.
- Once D_VALID is asserted, it and D_OUT stay stable until the beat is accepted or reset occurs.
- OUT_W = 48: BEATS = 1, and D_LAST is always equal to D_VALID.
- Reset, i.e. RST_N low at an edge:
  - count = 0, beat = 0, and pointers = 0.
  - Partial words are discarded.
  - Output values after reset: D_VALID = 0, D_LAST = 0, BUSY = 0, P_READY = CE, D_OUT = head slice of the buffer (the buffer contents are not cleared).

## Timing

- Input-to-output latency: a word pushed at edge k produces its first beat on D_OUT with D_VALID high in the cycle after edge k (1 cycle). This holds when the buffer was empty.
- Throughput: one beat per cycle while D_READY and CE are high.
- Words follow each other with no bubble. The beat after the last beat of word n is beat 0 of word n+1, provided word n+1 is already buffered.
- Sustained input rate: one word per BEATS cycles without stalling P_VALID.
- P_READY is a function of registered count and CE only. It has no combinational path from D_READY.
- D_VALID, D_OUT and D_LAST are functions of registered state only.

## Configuration

- Macro: P_UNPACK_PARITY_EN.
- Defined:
  - Adds output port D_PAR, 1 bit, equal to ^D_OUT (even parity over the current beat).
  - D_PAR is combinational from registered state, with the same timing as D_OUT.
  - D_PAR is 0 while D_VALID is low.
- Undefined: the D_PAR port and its logic are absent. All other behaviour is identical.

## Test plan

- Single word: OUT_W = 16, push 0x1234_5678_9ABC with D_READY = 1.
  - D_OUT = 0x9ABC, 0x5678, 0x1234 on three consecutive cycles, starting the cycle after the push.
  - D_LAST is high only on 0x1234.
  - D_VALID drops afterwards.
- Full buffer: hold D_READY = 0 and push words A and B.
  - P_READY goes low after the second push, and a third P_VALID is not accepted.
  - Release D_READY: 6 beats follow (A then B) with no bubble, and P_READY returns high in the cycle after A's last beat.
- Backpressure: toggle D_READY every cycle during a word.
  - Each beat is held stable until accepted.
  - The beat order is unchanged, and there are no duplicates or drops.
- CE freeze: drop CE mid-word for 4 cycles with D_READY = 1.
  - beat and count are unchanged, P_READY = 0, and D_OUT holds.
  - The word resumes at the same beat when CE returns.
- Reset mid-operation: RST_N = 0 for one edge during beat 1 with one word queued.
  - D_VALID = 0 and BUSY = 0 in the next cycle.
  - A new push produces beat 0 of the new word only.
- With P_UNPACK_PARITY_EN defined: D_OUT = 0x0007 gives D_PAR = 1, and D_OUT = 0x0003 gives D_PAR = 0.

Source files
------------

// File: rtl/dsp_p_unpacker.sv
// Buffers 48-bit DSP P results in a 2-entry FIFO and serializes each onto an
// OUT_W-bit stream, LSB slice first. Optional D_PAR output: `define P_UNPACK_PARITY_EN.
module dsp_p_unpacker #(
  parameter int OUT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [47:0]      P_IN,
  input  logic             P_VALID,
  output logic             P_READY,
  output logic [OUT_W-1:0] D_OUT,
  output logic             D_VALID,
  input  logic             D_READY,
  output logic             D_LAST,
`ifdef P_UNPACK_PARITY_EN
  output logic             D_PAR,
`endif
  output logic             BUSY
);

  localparam int BEATS = 48 / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [47:0]   mem_q [2];
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [47:0]      head_word;
  logic [OUT_W-1:0] beat_slice;
  logic             last_beat;
  logic             push;
  logic             xfer;
  logic             pop;

  // Outputs depend only on registered state (and CE for P_READY), never on D_READY.
  assign P_READY = CE && (count_q != 2'd2);
  assign D_VALID = (count_q != 2'd0);
  assign BUSY    = D_VALID;
  assign D_OUT   = beat_slice;
  assign D_LAST  = D_VALID && last_beat;
`ifdef P_UNPACK_PARITY_EN
  assign D_PAR   = D_VALID && (^beat_slice);
`endif

  assign push = P_VALID && P_READY;
  assign xfer = CE && D_VALID && D_READY;
  assign pop  = xfer && last_beat;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_word  = mem_q[head_q];
    beat_slice = head_word[OUT_W-1:0];
    for (int i = 1; i < BEATS; i++) begin
      if (beat_q == BW'(i)) beat_slice = head_word[i*OUT_W +: OUT_W];
    end
    last_beat = (beat_q == BW'(BEATS-1));
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    beat_d  = beat_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (push) tail_d = ~tail_q;
    if (xfer) begin
      if (last_beat) begin
        beat_d = '0;
        head_d = ~head_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      beat_q  <= '0;
    end else if (CE) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: the data storage is deliberately not reset; count gates validity,
  // so clearing the words would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (RST_N && push) mem_q[tail_q] <= P_IN;
  end

endmodule
